// File: rtl/text_writer_if.sv
// Byte stream into the text writer: character plus attribute
// with a valid/ready handshake.
interface text_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic [7:0] in_attr;

  modport master (
    output in_valid,
    output in_char,
    output in_attr,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_char,
    input  in_attr,
    output in_ready
  );
endinterface

// File: rtl/text_writer.sv
// Write-side engine for the 80x25 text RAM: prints bytes, handles
// CR/LF/BS/FF, scrolls on overflow and drives the display cursor.
module text_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          clock,
  input  logic          reset,
  text_writer_if.slave  in_if,
  output logic [11:0]   mem_address,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic [10:0]   cursor
);

  localparam int         CELLS     = COLS * ROWS;
  localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
  localparam logic [10:0] LAST_ROW  = 11'(CELLS - COLS);
  localparam logic [10:0] COLS_C    = 11'(COLS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
  localparam logic [11:0] LAST_BYTE = 12'(2 * CELLS - 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [3:0] {
    IDLE,
    PUT_C,
    PUT_A,
    SCR_RD,
    SCR_WR,
    FILL_C,
    FILL_A,
    CLS_C,
    CLS_A
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cursor_q, cursor_d;
  logic [6:0]  col_q, col_d;
  logic [10:0] cell_q, cell_d;
  logic [11:0] src_q, src_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;

  logic ready;
  logic accept;
  logic is_cr, is_lf, is_bs, is_ff;

  assign ready          = (state_q == IDLE);
  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid && ready;
  assign cursor         = cursor_q;

  assign is_cr = (in_if.in_char == CH_CR);
  assign is_lf = (in_if.in_char == CH_LF);
  assign is_bs = (in_if.in_char == CH_BS);
  assign is_ff = (in_if.in_char == CH_FF);

  // Next-state, cursor bookkeeping and RAM port decode.
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    col_d       = col_q;
    cell_d      = cell_q;
    src_d       = src_q;
    char_d      = char_q;
    attr_d      = attr_q;
    mem_we      = 1'b0;
    mem_address = 12'd0;
    mem_wdata   = 8'd0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          char_d = in_if.in_char;
          attr_d = in_if.in_attr;
          unique case (1'b1)
            is_cr: begin
              cursor_d = cursor_q - {4'd0, col_q};
              col_d    = 7'd0;
            end
            is_lf: begin
              col_d = 7'd0;
              if (cursor_q >= LAST_ROW) begin
                cursor_d = LAST_ROW;
                src_d    = ROW_BYTES;
                state_d  = SCR_RD;
              end else begin
                cursor_d = cursor_q - {4'd0, col_q} + COLS_C;
              end
            end
            is_bs: begin
              if (col_q != 7'd0) begin
                cursor_d = cursor_q - 11'd1;
                col_d    = col_q - 7'd1;
              end
            end
            is_ff: begin
              cursor_d = 11'd0;
              col_d    = 7'd0;
              cell_d   = 11'd0;
              state_d  = CLS_C;
            end
            default: state_d = PUT_C;
          endcase
        end
      end
      PUT_C: begin
        mem_we      = 1'b1;
        mem_address = {cursor_q, 1'b0};
        mem_wdata   = char_q;
        state_d     = PUT_A;
      end
      PUT_A: begin
        mem_we      = 1'b1;
        mem_address = {cursor_q, 1'b1};
        mem_wdata   = attr_q;
        if (cursor_q == LAST_CELL) begin
          cursor_d = LAST_ROW;
          col_d    = 7'd0;
          src_d    = ROW_BYTES;
          state_d  = SCR_RD;
        end else begin
          cursor_d = cursor_q + 11'd1;
          col_d    = (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
          state_d  = IDLE;
        end
      end
      SCR_RD: begin
        mem_address = src_q;
        state_d     = SCR_WR;
      end
      SCR_WR: begin
        mem_we      = 1'b1;
        mem_address = src_q - ROW_BYTES;
        mem_wdata   = mem_rdata;
        if (src_q == LAST_BYTE) begin
          cell_d  = LAST_ROW;
          state_d = FILL_C;
        end else begin
          src_d   = src_q + 12'd1;
          state_d = SCR_RD;
        end
      end
      FILL_C: begin
        mem_we      = 1'b1;
        mem_address = {cell_q, 1'b0};
        mem_wdata   = BLANK;
        state_d     = FILL_A;
      end
      FILL_A: begin
        mem_we      = 1'b1;
        mem_address = {cell_q, 1'b1};
        mem_wdata   = attr_q;
        if (cell_q == LAST_CELL) begin
          state_d = IDLE;
        end else begin
          cell_d  = cell_q + 11'd1;
          state_d = FILL_C;
        end
      end
      CLS_C: begin
        mem_we      = 1'b1;
        mem_address = {cell_q, 1'b0};
        mem_wdata   = BLANK;
        state_d     = CLS_A;
      end
      CLS_A: begin
        mem_we      = 1'b1;
        mem_address = {cell_q, 1'b1};
        mem_wdata   = attr_q;
        if (cell_q == LAST_CELL) begin
          state_d = IDLE;
        end else begin
          cell_d  = cell_q + 11'd1;
          state_d = CLS_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any pass in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cursor_q <= 11'd0;
      col_q    <= 7'd0;
      cell_q   <= 11'd0;
      src_q    <= 12'd0;
      char_q   <= 8'd0;
      attr_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      col_q    <= col_d;
      cell_q   <= cell_d;
      src_q    <= src_d;
      char_q   <= char_d;
      attr_q   <= attr_d;
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: a model queues expected RAM
// writes at issue time and a negedge monitor pops and compares.
module tb_text_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [10:0] cursor;

  always #5 clock = ~clock;

  text_writer_if bus ();

  text_writer dut (
    .clock       (clock),
    .reset       (reset),
    .in_if       (bus.slave),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .cursor      (cursor)
  );

  int checks   = 0;
  int failures = 0;
  int wcount   = 0;
  int cyc      = 0;
  int mcur     = 0;

  logic [19:0] exp_q[$];
  logic [19:0] e;
  logic [7:0]  acc_chars[$];
  int          acc_cyc[$];
  logic [7:0]  ram [0:4095];
  logic [7:0]  mdl [0:4095];
  logic        preload = 1'b0;

  // Synchronous text RAM with one-cycle read latency.
  always @(posedge clock) begin
    if (preload) begin
      for (int a = 0; a < 4096; a++) ram[a] <= a[7:0];
    end else if (mem_we) begin
      ram[mem_address] <= mem_wdata;
    end
    mem_rdata <= ram[mem_address];
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare each presented write against the queue head.
  always @(negedge clock) begin
    if (mem_we) begin
      wcount++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%02h expected none",
                 mem_address, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_address, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write addr=%0d data=%02h expected addr=%0d data=%02h",
                   mem_address, mem_wdata, e[19:8], e[7:0]);
        end
      end
    end
    checks++;
    if (mem_address > 12'd3999 || cursor > 11'd1999) begin
      failures++;
      $display("FAIL range addr=%0d cursor=%0d limits 3999/1999",
               mem_address, cursor);
    end
    if (bus.in_valid && bus.in_ready) begin
      acc_chars.push_back(bus.in_char);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input logic [7:0] d);
    logic [11:0] a12;
    a12 = addr[11:0];
    exp_q.push_back({a12, d});
    mdl[addr] = d;
  endtask

  task automatic scroll_exp(input logic [7:0] a);
    for (int s = 160; s < 4000; s++) push(s - 160, mdl[s]);
    for (int c = 1920; c < 2000; c++) begin
      push(2 * c, 8'h20);
      push(2 * c + 1, a);
    end
  endtask

  task automatic model(input logic [7:0] c, input logic [7:0] a);
    case (c)
      8'h0D: mcur = mcur - (mcur % 80);
      8'h0A: begin
        if (mcur >= 1920) begin
          scroll_exp(a);
          mcur = 1920;
        end else begin
          mcur = mcur - (mcur % 80) + 80;
        end
      end
      8'h08: if (mcur % 80 != 0) mcur = mcur - 1;
      8'h0C: begin
        for (int i = 0; i < 4000; i++) push(i, i[0] ? a : 8'h20);
        mcur = 0;
      end
      default: begin
        push(2 * mcur, c);
        push(2 * mcur + 1, a);
        if (mcur == 1999) begin
          scroll_exp(a);
          mcur = 1920;
        end else begin
          mcur = mcur + 1;
        end
      end
    endcase
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_attr  = a;
    n = 0;
    while (!bus.in_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout char=%02h ready=0 expected 1", c);
      bus.in_valid = 1'b0;
    end else begin
      model(c, a);
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout ready=0 expected 1", name);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] rdy_pat, we_pat;
    int n, bad, base;
    logic [7:0] ev;

    bus.in_valid = 1'b0;
    bus.in_char  = 8'd0;
    bus.in_attr  = 8'd0;
    reset        = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_cursor", cursor, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;

    send(8'h41, 8'h17);
    for (int i = 2; i >= 0; i--) begin
      @(negedge clock);
      rdy_pat[i] = bus.in_ready;
      we_pat[i]  = mem_we;
    end
    check("put_ready_gap", rdy_pat, 3'b001);
    check("put_we_pattern", we_pat, 3'b110);
    check("cursor_after_A", cursor, 1);

    send(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 8'h07);
    wait_idle("row1");
    check("cursor_85", cursor, 85);
    send(8'h0D, 8'h07);
    @(negedge clock);
    check("cr_ready_nowe", {bus.in_ready, mem_we}, 2'b10);
    check("cursor_cr", cursor, 80);
    send(8'h08, 8'h07);
    @(negedge clock);
    check("bs_col0", cursor, 80);
    send(8'h78, 8'h07);
    send(8'h08, 8'h07);
    wait_idle("bs");
    check("bs_back", cursor, 80);

    for (int i = 0; i < 23; i++) send(8'h0A, 8'h07);
    for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 10), 8'h07);
    wait_idle("to_1999");
    check("cursor_1999", cursor, 1999);

    @(negedge clock);
    preload = 1'b1;
    for (int a = 0; a < 4096; a++) mdl[a] = a[7:0];
    @(negedge clock);
    preload = 1'b0;

    send(8'h5A, 8'h1F);
    wait_idle("wrap_scroll");
    check("cursor_wrap", cursor, 1920);
    check("wrap_queue_left", exp_q.size(), 0);
    bad = 0;
    for (int a = 0; a < 4000; a++) begin
      if (a < 3838) begin
        n  = a + 160;
        ev = n[7:0];
      end else if (a == 3838) ev = 8'h5A;
      else if (a == 3839) ev = 8'h1F;
      else ev = a[0] ? 8'h1F : 8'h20;
      if (ram[a] !== ev) bad++;
    end
    check("wrap_ram_bad_bytes", bad, 0);

    for (int i = 0; i < 30; i++) send(8'h41 + 8'(i % 26), 8'h07);
    wait_idle("to_1950");
    check("cursor_1950", cursor, 1950);
    send(8'h0A, 8'h4E);
    n = 0;
    do begin
      @(negedge clock);
      if (!bus.in_ready) n++;
    end while (!bus.in_ready && n < 20000);
    check("lf_busy_cycles", n, 7840);
    check("cursor_lf_scroll", cursor, 1920);
    check("lf_queue_left", exp_q.size(), 0);

    send(8'h0C, 8'h07);
    wait_idle("clear");
    check("cursor_clear", cursor, 0);
    check("clear_queue_left", exp_q.size(), 0);

    base = wcount;
    send(8'h0C, 8'h07);
    n = 0;
    while (wcount < base + 1000 && n < 20000) begin
      @(posedge clock);
      #1 n++;
    end
    check("abort_reached_1000", (wcount >= base + 1000) ? 1 : 0, 1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("abort_we", mem_we, 0);
    check("abort_cursor", cursor, 0);
    check("abort_ready", bus.in_ready, 1);
    check("abort_writes_left", exp_q.size(), 2999);
    exp_q.delete();
    mcur = 0;

    acc_chars.delete();
    acc_cyc.delete();
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_attr  = 8'h07;
    for (int i = 0; i < 10; i++) begin
      bus.in_char = 8'h61 + 8'(i);
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(negedge clock);
        n++;
      end
      model(bus.in_char, 8'h07);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_idle("hold");
    check("hold_accepts", acc_chars.size(), 10);
    bad = 0;
    for (int i = 0; i < acc_chars.size(); i++) begin
      ev = 8'h61 + 8'(i);
      if (acc_chars[i] !== ev) bad++;
    end
    check("hold_char_order_bad", bad, 0);
    bad = 0;
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != 3) bad++;
    check("hold_interval_bad", bad, 0);
    check("hold_cursor", cursor, 10);
    check("hold_queue_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
